// File: rtl/led_breathe.sv
// led_breathe: breathing PWM LED driver; duty ramps up, holds, ramps down, holds,
// and pulses breath_done once per completed breath.
module led_breathe #(
    parameter int PWM_BITS   = 8,
    parameter int RAMP_DIV   = 46875,
    parameter int HOLD_STEPS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [2:0]          phase,
    output logic                breath_done
);
    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] MAX_M1   = MAX - ONE;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [PWM_BITS-1:0] pwm_cnt, duty_q, duty_n;
    logic [PRE_W-1:0]    pre_cnt, pre_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                step, done_n;

    assign step  = pre_cnt == PRE_LAST;
    assign phase = state;

    // Ramps end on the step that reaches the extreme, so each ramp is MAX steps long.
    always_comb begin
        state_n = state;
        duty_n  = duty;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
        pre_n   = (state == OFF || step) ? '0 : pre_cnt + 1'b1;
        if (!en) begin
            state_n = OFF;
            duty_n  = '0;
            hold_n  = '0;
            pre_n   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_n = RISE;
                    duty_n  = '0;
                end
                RISE: if (step) begin
                    duty_n = (duty == MAX) ? MAX : duty + ONE;
                    if (duty >= MAX_M1) begin
                        state_n = HOLD_HI;
                        hold_n  = '0;
                    end
                end
                HOLD_HI: if (step) begin
                    hold_n  = hold_cnt + 1'b1;
                    state_n = (hold_cnt == HOLD_LAST) ? FALL : HOLD_HI;
                end
                FALL: if (step) begin
                    duty_n = (duty == '0) ? '0 : duty - ONE;
                    if (duty <= ONE) begin
                        state_n = HOLD_LO;
                        hold_n  = '0;
                    end
                end
                HOLD_LO: if (step) begin
                    hold_n = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = RISE;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = OFF;
                    duty_n  = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= OFF;
            duty        <= '0;
            pre_cnt     <= '0;
            hold_cnt    <= '0;
            breath_done <= 1'b0;
            pwm_cnt     <= '0;
            duty_q      <= '0;
            led         <= 1'b0;
        end else begin
            state       <= state_n;
            duty        <= duty_n;
            pre_cnt     <= pre_n;
            hold_cnt    <= hold_n;
            breath_done <= done_n;
            pwm_cnt     <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX)
                duty_q <= duty;
            led         <= pwm_cnt < duty_q;
        end
    end
endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: directed checks of ramp timing, PWM shape, enable and reset corners.
module tb_led_breathe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic       led0, led1, led2, bd0, bd1, bd2;
    logic [2:0] duty0, duty1, duty2, ph0, ph1, ph2;
    int checks = 0;
    int errors = 0;
    int t = -1;
    int bd_cnt = 0;

    typedef struct {
        int   t;
        logic en;
        int   ph;
        int   du;
        int   bd;
    } vec_t;
    vec_t tbl [0:19];
    int exp_d1 [0:10];
    int exp_p1 [0:10];

    always #5 clk = ~clk;

    led_breathe #(.PWM_BITS(3), .RAMP_DIV(4), .HOLD_STEPS(2)) dut0 (
        .clk(clk), .reset(reset), .en(en), .led(led0), .duty(duty0), .phase(ph0), .breath_done(bd0));
    led_breathe #(.PWM_BITS(3), .RAMP_DIV(1), .HOLD_STEPS(2)) dut1 (
        .clk(clk), .reset(reset), .en(en), .led(led1), .duty(duty1), .phase(ph1), .breath_done(bd1));
    led_breathe #(.PWM_BITS(3), .RAMP_DIV(32), .HOLD_STEPS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .led(led2), .duty(duty2), .phase(ph2), .breath_done(bd2));

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        t = -1;
    endtask

    task automatic run_to(input int target);
        while (t < target) begin
            tick();
            bd_cnt += int'(bd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl = '{
            '{0,   1'b1, 1, 0, 0}, '{3,   1'b1, 1, 0, 0}, '{4,   1'b1, 1, 1, 0},
            '{8,   1'b1, 1, 2, 0}, '{27,  1'b1, 1, 6, 0}, '{28,  1'b1, 2, 7, 0},
            '{35,  1'b1, 2, 7, 0}, '{36,  1'b1, 3, 7, 0}, '{40,  1'b1, 3, 6, 0},
            '{44,  1'b1, 3, 5, 0}, '{63,  1'b1, 3, 1, 0}, '{64,  1'b1, 4, 0, 0},
            '{71,  1'b1, 4, 0, 0}, '{72,  1'b1, 1, 0, 1}, '{73,  1'b1, 1, 0, 0},
            '{76,  1'b1, 1, 1, 0}, '{100, 1'b1, 2, 7, 0}, '{136, 1'b1, 4, 0, 0},
            '{144, 1'b1, 1, 0, 1}, '{145, 1'b1, 1, 0, 0}
        };
        exp_d1 = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 6};
        exp_p1 = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3};

        // reset held with en high
        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_led", led0, 0);
            chk("rst_duty", duty0, 0);
            chk("rst_phase", ph0, 0);
            chk("rst_bd", bd0, 0);
        end
        reset = 1'b0;
        t = -1;

        // two full breaths
        for (int i = 0; i < 20; i++) begin
            run_to(tbl[i].t);
            chk("breath_phase", ph0, tbl[i].ph);
            chk("breath_duty", duty0, tbl[i].du);
            chk("breath_done", bd0, tbl[i].bd);
            en = tbl[i].en;
        end
        chk("breath_done_count", bd_cnt, 2);

        // en dropped mid-FALL at duty 5
        restart();
        run_to(45);
        chk("fall_pre_phase", ph0, 3);
        chk("fall_pre_duty", duty0, 5);
        en = 1'b0;
        tick();
        chk("en_off_phase", ph0, 0);
        chk("en_off_duty", duty0, 0);
        chk("en_off_bd", bd0, 0);
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("en_off_led", led0, 0);
            chk("en_off_bd_hold", bd0, 0);
            chk("en_off_phase_hold", ph0, 0);
        end
        en = 1'b1;
        tick();
        chk("reen_phase", ph0, 1);
        chk("reen_duty", duty0, 0);
        repeat (3) tick();
        chk("reen_duty_hold", duty0, 0);
        tick();
        chk("reen_duty_step", duty0, 1);

        // en dropped on the final HOLD_LO step: no breath_done
        restart();
        run_to(71);
        chk("holdlo_pre_phase", ph0, 4);
        en = 1'b0;
        tick();
        chk("holdlo_off_phase", ph0, 0);
        chk("holdlo_off_bd", bd0, 0);

        // reset mid-RISE at duty 6, with en high then en low
        for (int k = 0; k < 2; k++) begin
            restart();
            run_to(25);
            chk("rise_pre_duty", duty0, 6);
            reset = 1'b1;
            en = (k == 0);
            tick();
            chk("midrst_led", led0, 0);
            chk("midrst_duty", duty0, 0);
            chk("midrst_phase", ph0, 0);
            chk("midrst_bd", bd0, 0);
        end

        // RAMP_DIV=1: step every cycle, saturating at 7
        restart();
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("div1_duty", duty1, exp_d1[i]);
            chk("div1_phase", ph1, exp_p1[i]);
        end

        // PWM waveform on the RAMP_DIV=32 instance
        restart();
        for (int s = 0; s <= 311; s++) begin
            tick();
            if (s <= 30)
                chk("pwm_duty0_led", led2, 0);
            else if (s >= 104 && s <= 127)
                chk("pwm_duty3_led", led2, (s % 8) < 3);
            else if (s >= 232)
                chk("pwm_duty7_led", led2, (s % 8) != 7);
            if (s == 100)
                chk("pwm_duty3_val", duty2, 3);
            if (s == 250)
                chk("pwm_duty7_val", duty2, 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
